fetch_unit: RTL

Instruction-fetch stage that drives `instruction_memory`: holds the program counter, presents it as the memory word address, and registers the returned instruction into an IF/ID output register with a valid/ready handshake toward the decoder. It handles sequential advance, branch redirect with flush, back-pressure stalls, and halts after delivering an ECALL.

---
 rtl/riscv_pkg.sv | 25 ++
 rtl/program_counter.sv | 38 +++
 rtl/fetch_unit.sv | 101 ++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: fetch FSM state encoding, the ECALL word,
// and the major opcode values reused by the decoder.
package riscv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] INSTR_ECALL = 32'h0000_0073;

  // Major opcodes (instruction bits [6:0])
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

endpackage

// File: rtl/program_counter.sv
// Program counter register: redirect load has priority over increment,
// otherwise holds. Increment wraps modulo 2^ADDR_W.
module program_counter #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] load_addr_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] pc_o
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  // Next PC: redirect, sequential advance, or hold
  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_addr_i;
    end else if (inc_i) begin
      pc_d = pc_q + ADDR_W'(1);
    end
  end

  // PC register with synchronous clear
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the instruction memory
// address, and holds the fetched word in an IF/ID register handed to the
// decoder with a valid/ready handshake. Stops fetching after an ECALL.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int i_addr_bits      = 6,
  parameter int INSTRUCTION_SIZE = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  output logic [i_addr_bits-1:0]      imem_addr,
  input  logic [INSTRUCTION_SIZE-1:0] imem_instruction,
  input  logic                        branch_taken,
  input  logic [i_addr_bits-1:0]      branch_target,
  output logic                        if_valid,
  input  logic                        id_ready,
  output logic [INSTRUCTION_SIZE-1:0] if_instruction,
  output logic [i_addr_bits-1:0]      if_pc,
  output logic                        halted
);

  fetch_state_e                  state_q;
  logic                          valid_q;
  logic [INSTRUCTION_SIZE-1:0]   instr_q;
  logic [i_addr_bits-1:0]        ifpc_q;
  logic                          halted_q;

  logic [i_addr_bits-1:0]        pc;
  logic                          capture;
  logic                          redirect;
  logic                          advance;
  logic                          fetched_ecall;

  // Output register is free when empty or being consumed this cycle
  assign capture       = !valid_q || id_ready;
  assign redirect      = (state_q == ST_RUN) && branch_taken;
  assign advance       = (state_q == ST_RUN) && !branch_taken && capture;
  assign fetched_ecall = (imem_instruction == INSTRUCTION_SIZE'(INSTR_ECALL));

  program_counter #(
    .ADDR_W (i_addr_bits)
  ) u_pc (
    .clk         (clk),
    .reset       (reset),
    .load_i      (redirect),
    .load_addr_i (branch_target),
    .inc_i       (advance),
    .pc_o        (pc)
  );

  // Fetch FSM and IF/ID output register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      valid_q  <= 1'b0;
      instr_q  <= '0;
      ifpc_q   <= '0;
      halted_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (branch_taken) begin
            // Drop whatever is held; the target arrives after one bubble
            valid_q <= 1'b0;
          end else if (capture) begin
            instr_q <= imem_instruction;
            ifpc_q  <= pc;
            valid_q <= 1'b1;
            if (fetched_ecall) begin
              state_q  <= ST_HALT;
              halted_q <= 1'b1;
            end
          end
        end
        ST_HALT: begin
          // The ECALL stays visible until the decoder takes it
          if (valid_q && id_ready) begin
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign imem_addr      = pc;
  assign if_valid       = valid_q;
  assign if_instruction = instr_q;
  assign if_pc          = ifpc_q;
  assign halted         = halted_q;

endmodule
